// File: rtl/nlm_pkg.sv
// Shared definitions for the NLM line buffer: border padding modes and the
// derivation of the column height / bank count from the NLM radii.
package nlm_pkg;

    localparam int unsigned PAD_ZERO = 0;
    localparam int unsigned PAD_REPL = 1;

    // Column height: patch plus search reach above and below the centre row.
    function automatic int unsigned num_lines(input int unsigned block_radius,
                                              input int unsigned win_radius);
        return 2 * (block_radius + win_radius) + 1;
    endfunction

    // Only the history rows need storage; the current row comes straight in.
    function automatic int unsigned num_banks(input int unsigned block_radius,
                                              input int unsigned win_radius);
        return num_lines(block_radius, win_radius) - 1;
    endfunction

endpackage

// File: rtl/nlm_line_buffer_if.sv
// Pixel-in / column-out stream bundle of the NLM line buffer.
//   pix_i, sof_i, in_valid_i / in_ready_o       : input pixel stream
//   col_o, col_x_o, sof_o, eol_o                : output column and position tags
//   out_valid_o / out_ready_i                   : output column handshake
// slave = the line buffer, master = the producer/consumer side around it.
interface nlm_line_buffer_if
    import nlm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned NUM_LINES  = num_lines(2, 6)
);
    logic [DATA_WIDTH-1:0]           pix_i;
    logic                            sof_i;
    logic                            in_valid_i;
    logic                            in_ready_o;
    logic [NUM_LINES*DATA_WIDTH-1:0] col_o;
    logic [ADDR_WIDTH-1:0]           col_x_o;
    logic                            sof_o;
    logic                            eol_o;
    logic                            out_valid_o;
    logic                            out_ready_i;

    modport slave (
        input  pix_i, sof_i, in_valid_i, out_ready_i,
        output in_ready_o, col_o, col_x_o, sof_o, eol_o, out_valid_o
    );

    modport master (
        output pix_i, sof_i, in_valid_i, out_ready_i,
        input  in_ready_o, col_o, col_x_o, sof_o, eol_o, out_valid_o
    );

endinterface

// File: rtl/lb_sram_bank.sv
// One line of pixel storage. Synchronous read that holds its output while
// rden is low; a same-cycle write returns the previous contents on rdata.
//   clk, rst_n : clock, async active-low reset (clears rdata only)
//   rden, wren : read / write enables
//   addr       : column address
//   wdata      : pixel to store
//   rdata      : registered read data
module lb_sram_bank #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DEPTH      = 1920
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rden,
    input  logic                  wren,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
    localparam int unsigned MEM_AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage array: no reset, stale contents are masked upstream.
    always_ff @(posedge clk) begin
        if (wren) begin
            mem[MEM_AW'(addr)] <= wdata;
        end
    end

    // Read port: old data wins over a same-cycle write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (rden) begin
            rdata <= mem[MEM_AW'(addr)];
        end
    end

endmodule

// File: rtl/nlm_line_buffer.sv
// Rotating multi-line buffer for the NLM window stage. Keeps the last
// NUM_LINES-1 lines in rotating banks and emits one vertical column per
// accepted pixel (oldest row in slice 0, current pixel in the top slice),
// with top-border padding before enough lines have arrived.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of nlm_line_buffer_if (pixel in, column out)
module nlm_line_buffer
    import nlm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 12,
    parameter int unsigned ADDR_WIDTH   = 12,
    parameter int unsigned LINE_WIDTH   = 1920,
    parameter int unsigned BLOCK_RADIUS = 2,
    parameter int unsigned WIN_RADIUS   = 6,
    parameter int unsigned PAD_MODE     = PAD_REPL
) (
    input  logic             clk,
    input  logic             rst_n,
    nlm_line_buffer_if.slave bus
);
    localparam int unsigned NUM_LINES = num_lines(BLOCK_RADIUS, WIN_RADIUS);
    localparam int unsigned NUM_BANKS = num_banks(BLOCK_RADIUS, WIN_RADIUS);
    localparam int unsigned BANK_W    = $clog2(NUM_BANKS);
    localparam int unsigned SEL_W     = $clog2(NUM_LINES);

    logic                  fire;
    logic [ADDR_WIDTH-1:0] x_cnt;
    logic [SEL_W-1:0]      line_cnt;
    logic [BANK_W-1:0]     wr_bank;
    logic [ADDR_WIDTH-1:0] x_eff;
    logic [SEL_W-1:0]      line_eff;
    logic                  x_last;

    // State captured with each accepted pixel; drives the column mux.
    logic [BANK_W-1:0]     wr_bank_s;
    logic [SEL_W-1:0]      line_s;
    logic [DATA_WIDTH-1:0] pix_s;
    logic [ADDR_WIDTH-1:0] col_x_q;
    logic                  sof_q;
    logic                  eol_q;
    logic                  out_valid_q;

    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] bank_rdata;
    logic [NUM_LINES-1:0][DATA_WIDTH-1:0] raw;
    logic [NUM_LINES-1:0][DATA_WIDTH-1:0] col;
    int                                   idx;
    int                                   first;

    assign bus.in_ready_o = bus.out_ready_i | ~out_valid_q;
    assign fire           = bus.in_valid_i & bus.in_ready_o;

    // sof_i restarts the frame on the pixel that carries it.
    assign x_eff    = bus.sof_i ? '0 : x_cnt;
    assign line_eff = bus.sof_i ? '0 : line_cnt;
    assign x_last   = (x_eff == ADDR_WIDTH'(LINE_WIDTH - 1));

    // Column / line counters and write-bank pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt    <= '0;
            line_cnt <= '0;
            wr_bank  <= '0;
        end else if (fire) begin
            x_cnt    <= x_last ? '0 : ADDR_WIDTH'(x_eff + 1'b1);
            line_cnt <= line_eff;
            if (x_last) begin
                if (line_eff != SEL_W'(NUM_LINES - 1)) begin
                    line_cnt <= SEL_W'(line_eff + 1'b1);
                end
                wr_bank <= (wr_bank == BANK_W'(NUM_BANKS - 1)) ? '0 : BANK_W'(wr_bank + 1'b1);
            end
        end
    end

    // Output tags and mux controls, loaded alongside the bank reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_s   <= '0;
            line_s      <= '0;
            pix_s       <= '0;
            col_x_q     <= '0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (fire) begin
            wr_bank_s   <= wr_bank;
            line_s      <= line_eff;
            pix_s       <= bus.pix_i;
            col_x_q     <= x_eff;
            sof_q       <= bus.sof_i;
            eol_q       <= x_last;
            out_valid_q <= 1'b1;
        end else if (bus.out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    for (genvar b = 0; b < int'(NUM_BANKS); b++) begin : g_bank
        lb_sram_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .DEPTH      (LINE_WIDTH)
        ) u_bank (
            .clk   (clk),
            .rst_n (rst_n),
            .rden  (fire),
            .wren  (fire && (wr_bank == BANK_W'(b))),
            .addr  (x_eff),
            .wdata (bus.pix_i),
            .rdata (bank_rdata[b])
        );
    end

    // Rotate banks into row order, then mask rows above the frame top.
    // Bank rdata and the captured controls only change on fire, so the
    // column holds during a stall.
    always_comb begin
        raw   = '0;
        col   = '0;
        idx   = 0;
        first = 0;
        for (int k = 0; k < int'(NUM_BANKS); k++) begin
            idx = int'(wr_bank_s) + k;
            if (idx >= int'(NUM_BANKS)) begin
                idx = idx - int'(NUM_BANKS);
            end
            raw[SEL_W'(k)] = bank_rdata[BANK_W'(idx)];
        end
        raw[SEL_W'(NUM_BANKS)] = pix_s;
        first = int'(NUM_BANKS) - int'(line_s);
        for (int k = 0; k < int'(NUM_LINES); k++) begin
            if (k >= first) begin
                col[SEL_W'(k)] = raw[SEL_W'(k)];
            end else if (PAD_MODE == PAD_REPL) begin
                col[SEL_W'(k)] = raw[SEL_W'(first)];
            end
        end
    end

    assign bus.col_o       = col;
    assign bus.col_x_o     = col_x_q;
    assign bus.sof_o       = sof_q;
    assign bus.eol_o       = eol_q;
    assign bus.out_valid_o = out_valid_q;

endmodule

// File: tb/tb_nlm_line_buffer.sv
// Bench for nlm_line_buffer: two instances (replicate and zero padding) share
// one stimulus stream; columns are captured and checked against hand values.
module tb_nlm_line_buffer;
    import nlm_pkg::*;

    localparam int unsigned DW = 12;
    localparam int unsigned AW = 12;
    localparam int unsigned LW = 8;
    localparam int unsigned NL = num_lines(2, 6);
    localparam int unsigned CW = NL * DW;

    typedef struct {
        logic [CW-1:0] col;
        logic [AW-1:0] x;
        logic          sof;
        logic          eol;
    } col_t;

    typedef struct {
        int pad;
        int line;
        int x;
        int k;
        int exp;
    } vec_t;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] pix;
    logic          sof;
    logic          in_valid;
    logic          out_ready;
    logic          rand_ready;

    int n_checks;
    int n_fail;

    col_t q1[$];
    col_t q0[$];
    col_t a1[$];
    col_t a0[$];
    vec_t tbl[$];

    nlm_line_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_LINES(NL)) bus1 ();
    nlm_line_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_LINES(NL)) bus0 ();

    assign bus1.pix_i       = pix;
    assign bus1.sof_i       = sof;
    assign bus1.in_valid_i  = in_valid;
    assign bus1.out_ready_i = out_ready;
    assign bus0.pix_i       = pix;
    assign bus0.sof_i       = sof;
    assign bus0.in_valid_i  = in_valid;
    assign bus0.out_ready_i = out_ready;

    nlm_line_buffer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINE_WIDTH(LW),
        .BLOCK_RADIUS(2), .WIN_RADIUS(6), .PAD_MODE(PAD_REPL)
    ) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    nlm_line_buffer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINE_WIDTH(LW),
        .BLOCK_RADIUS(2), .WIN_RADIUS(6), .PAD_MODE(PAD_ZERO)
    ) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture each column on the cycle it is handed downstream.
    always @(negedge clk) begin
        if (rst_n && bus1.out_valid_o && bus1.out_ready_i) begin
            q1.push_back('{col: bus1.col_o, x: bus1.col_x_o, sof: bus1.sof_o, eol: bus1.eol_o});
        end
        if (rst_n && bus0.out_valid_o && bus0.out_ready_i) begin
            q0.push_back('{col: bus0.col_o, x: bus0.col_x_o, sof: bus0.sof_o, eol: bus0.eol_o});
        end
    end

    function automatic int slice(input logic [CW-1:0] c, input int k);
        return int'(c[k*DW +: DW]);
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        sof        = 1'b0;
        pix        = '0;
        out_ready  = 1'b1;
        rand_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        q1.delete();
        q0.delete();
        @(posedge clk);
        #1;
    endtask

    // Present one pixel until accepted; bounded so a stuck ready cannot hang.
    task automatic send_pixel(input logic [DW-1:0] p, input logic s);
        int   guard;
        logic fired;
        guard    = 0;
        fired    = 1'b0;
        pix      = p;
        sof      = s;
        in_valid = 1'b1;
        while (!fired) begin
            @(negedge clk);
            fired = bus1.in_ready_o;
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
            guard++;
            if (guard > 200) begin
                $display("FAIL send_timeout: got no in_ready_o within 200 cycles");
                $fatal(1);
            end
        end
    endtask

    task automatic send_frame(input int nlines);
        for (int l = 0; l < nlines; l++) begin
            for (int x = 0; x < int'(LW); x++) begin
                send_pixel(DW'(l * 16 + x), (l == 0) && (x == 0));
            end
        end
    endtask

    task automatic drain();
        in_valid   = 1'b0;
        sof        = 1'b0;
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int   idx;
        col_t c;
        n_checks = 0;
        n_fail   = 0;

        // Reset holds everything idle even with a valid pixel offered.
        rst_n      = 1'b0;
        rand_ready = 1'b0;
        in_valid   = 1'b1;
        sof        = 1'b0;
        pix        = 12'hABC;
        out_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 256'(bus1.out_valid_o), 256'(0));
        check("rst_col",       256'(bus1.col_o),       256'(0));
        check("rst_in_ready",  256'(bus1.in_ready_o),  256'(1));
        check("rst_col_x",     256'(bus1.col_x_o),     256'(0));
        check("rst_col_pad0",  256'(bus0.col_o),       256'(0));

        // Run A: 21-line ramp, no backpressure.
        do_reset();
        send_frame(21);
        drain();
        a1 = q1;
        a0 = q0;
        check("runA_count_pad1", 256'(a1.size()), 256'(21 * LW));
        check("runA_count_pad0", 256'(a0.size()), 256'(21 * LW));

        tbl.push_back('{1, 20, 3,  0, 'h043});
        tbl.push_back('{1, 20, 3,  8, 'h0C3});
        tbl.push_back('{1, 20, 3, 15, 'h133});
        tbl.push_back('{1, 20, 3, 16, 'h143});
        tbl.push_back('{1,  2, 5,  0, 'h005});
        tbl.push_back('{1,  2, 5, 13, 'h005});
        tbl.push_back('{1,  2, 5, 14, 'h005});
        tbl.push_back('{1,  2, 5, 15, 'h015});
        tbl.push_back('{1,  2, 5, 16, 'h025});
        tbl.push_back('{1,  0, 6,  0, 'h006});
        tbl.push_back('{1,  0, 6, 16, 'h006});
        tbl.push_back('{1, 16, 4,  0, 'h004});
        tbl.push_back('{1, 16, 4, 16, 'h104});
        tbl.push_back('{1, 17, 7,  0, 'h017});
        tbl.push_back('{1, 17, 7,  9, 'h0A7});
        tbl.push_back('{1, 17, 7, 16, 'h117});
        tbl.push_back('{0,  1, 0,  0, 'h000});
        tbl.push_back('{0,  1, 0, 16, 'h010});
        tbl.push_back('{0,  1, 2, 14, 'h000});
        tbl.push_back('{0,  1, 2, 15, 'h002});
        tbl.push_back('{0,  1, 2, 16, 'h012});
        tbl.push_back('{0,  2, 5, 13, 'h000});
        tbl.push_back('{0,  2, 5, 14, 'h005});
        tbl.push_back('{0,  0, 6, 15, 'h000});
        tbl.push_back('{0,  0, 6, 16, 'h006});
        tbl.push_back('{0, 20, 3,  0, 'h043});

        foreach (tbl[i]) begin
            idx = tbl[i].line * int'(LW) + tbl[i].x;
            if (tbl[i].pad == 1 && idx < a1.size()) c = a1[idx];
            else if (tbl[i].pad == 0 && idx < a0.size()) c = a0[idx];
            else c = '{col: '1, x: '1, sof: 1'b1, eol: 1'b1};
            check($sformatf("vec%0d_p%0d_l%0d_x%0d_k%0d", i, tbl[i].pad, tbl[i].line, tbl[i].x, tbl[i].k),
                  256'(slice(c.col, tbl[i].k)), 256'(tbl[i].exp));
        end

        // Position tags on the run-A stream.
        if (a1.size() == 21 * LW) begin
            check("tag_sof_first", 256'(a1[0].sof),   256'(1));
            check("tag_sof_next",  256'(a1[1].sof),   256'(0));
            check("tag_eol_x7",    256'(a1[7].eol),   256'(1));
            check("tag_eol_x0",    256'(a1[8].eol),   256'(0));
            check("tag_col_x",     256'(a1[13].x),    256'(5));
            check("tag_eol_last",  256'(a1[167].eol), 256'(1));
        end

        // Run B: same frame with random downstream stalls.
        do_reset();
        rand_ready = 1'b1;
        send_frame(21);
        drain();
        check("runB_count_pad1", 256'(q1.size()), 256'(a1.size()));
        check("runB_count_pad0", 256'(q0.size()), 256'(a0.size()));
        for (int i = 0; i < q1.size() && i < a1.size(); i++) begin
            check($sformatf("bp_col_pad1_%0d", i),
                  256'({q1[i].col, q1[i].x, q1[i].sof, q1[i].eol}),
                  256'({a1[i].col, a1[i].x, a1[i].sof, a1[i].eol}));
        end
        for (int i = 0; i < q0.size() && i < a0.size(); i++) begin
            check($sformatf("bp_col_pad0_%0d", i),
                  256'({q0[i].col, q0[i].x, q0[i].sof, q0[i].eol}),
                  256'({a0[i].col, a0[i].x, a0[i].sof, a0[i].eol}));
        end

        // One-cycle latency and valid drop when nothing new arrives.
        do_reset();
        pix      = 12'h0AB;
        sof      = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        check("lat_before", 256'(bus1.out_valid_o), 256'(0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sof      = 1'b0;
        @(negedge clk);
        check("lat_valid", 256'(bus1.out_valid_o), 256'(1));
        check("lat_pix",   256'(slice(bus1.col_o, 16)), 256'('h0AB));
        @(negedge clk);
        check("lat_clear", 256'(bus1.out_valid_o), 256'(0));

        // Mid-line sof: lines 0..2, line 3 x0..4, then a restart pixel.
        do_reset();
        send_frame(3);
        for (int x = 0; x < 5; x++) send_pixel(DW'(3 * 16 + x), 1'b0);
        send_pixel(12'h777, 1'b1);
        send_pixel(12'h778, 1'b0);
        drain();
        check("sof_count", 256'(q1.size()), 256'(31));
        if (q1.size() == 31 && q0.size() == 31) begin
            check("pre_abort_k16", 256'(slice(q1[28].col, 16)), 256'('h034));
            check("pre_abort_k15", 256'(slice(q1[28].col, 15)), 256'('h024));
            check("sof_tag",       256'(q1[29].sof),            256'(1));
            check("sof_col_x",     256'(q1[29].x),              256'(0));
            check("sof_eol",       256'(q1[29].eol),            256'(0));
            check("sof_p1_k0",     256'(slice(q1[29].col, 0)),  256'('h777));
            check("sof_p1_k15",    256'(slice(q1[29].col, 15)), 256'('h777));
            check("sof_p1_k16",    256'(slice(q1[29].col, 16)), 256'('h777));
            check("sof_p0_k0",     256'(slice(q0[29].col, 0)),  256'(0));
            check("sof_p0_k15",    256'(slice(q0[29].col, 15)), 256'(0));
            check("sof_p0_k16",    256'(slice(q0[29].col, 16)), 256'('h777));
            check("post_sof_x",    256'(q1[30].x),              256'(1));
            check("post_sof_p0",   256'(slice(q0[30].col, 15)), 256'(0));
            check("post_sof_p1",   256'(slice(q1[30].col, 0)),  256'('h778));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
